// File: rtl/adc_slicer_pkg.sv
// Shared types for the ADC tape slicer: FSM state encoding and accumulator width helper.
package adc_slicer_pkg;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        ACC,
        CMP
    } state_e;

    function automatic int unsigned total_w(input int unsigned dw, input int unsigned depth_log2);
        return dw + depth_log2;
    endfunction

endpackage

// File: rtl/slicer_win_ram.sv
// Averaging-window storage: simple dual-port RAM with a one-clock registered read.
module slicer_win_ram #(
    parameter int unsigned DW = 12,
    parameter int unsigned AW = 9
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem_q [2**AW];
    logic [DW-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
        if (re) begin
            rdata_q <= mem_q[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/adc_tape_slicer.sv
// Cassette-input slicer: running-average high-pass over 2^DEPTH_LOG2 samples plus hysteresis comparator.
// Optional period measurement between bit_out edges is enabled by defining ADC_SLICER_PERIOD_EN.
module adc_tape_slicer
    import adc_slicer_pkg::*;
#(
    parameter int unsigned DW         = 12,
    parameter int unsigned DEPTH_LOG2 = 9,
    parameter int unsigned HYST       = 100,
    parameter int unsigned PER_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [DW-1:0]    din,
    input  logic             din_sync,
    output logic             bit_out,
    output logic             bit_edge,
    output logic [DW-1:0]    avg,
    output logic             ready,
    output logic             overrun,
    output logic [PER_W-1:0] period,
    output logic             period_valid
);

    localparam int unsigned           TW      = total_w(DW, DEPTH_LOG2);
    localparam logic [DW:0]           HYST_W  = (DW+1)'(HYST);
    localparam logic [DW:0]           MAX_W   = {1'b0, {DW{1'b1}}};
    localparam logic [DEPTH_LOG2:0]   FULL    = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0]   FULL_M1 = FULL - (DEPTH_LOG2+1)'(1);

    logic                  sync_q;
    logic                  ev;
    state_e                state_q;
    logic [DW-1:0]         smp_q;
    logic [DW-1:0]         avg_q;
    logic [TW-1:0]         total_q;
    logic [DEPTH_LOG2-1:0] wptr_q;
    logic [DEPTH_LOG2:0]   fill_q;
    logic                  ready_q;
    logic                  bit_q;
    logic                  edge_q;
    logic                  ovr_q;

    logic [DW-1:0]         ram_rd;
    logic [DW-1:0]         old_d;
    logic [DW-1:0]         avg_d;
    logic [DW:0]           lo_d;
    logic [DW:0]           hi_sum;
    logic [DW:0]           hi_d;
    logic                  bit_d;

    always_ff @(posedge clk) begin
        sync_q <= din_sync;
    end

    assign ev = sync_q ^ din_sync;

    slicer_win_ram #(
        .DW (DW),
        .AW (DEPTH_LOG2)
    ) u_ram (
        .clk   (clk),
        .we    (state_q == ACC),
        .waddr (wptr_q),
        .wdata (smp_q),
        .re    ((state_q == IDLE) && ev),
        .raddr (wptr_q),
        .rdata (ram_rd)
    );

    // Thresholds come from the average that CMP is about to publish, not the stale avg_q.
    always_comb begin
        avg_d  = total_q[TW-1:DEPTH_LOG2];
        lo_d   = ({1'b0, avg_d} >= HYST_W) ? ({1'b0, avg_d} - HYST_W) : '0;
        hi_sum = {1'b0, avg_d} + HYST_W;
        hi_d   = (hi_sum > MAX_W) ? MAX_W : hi_sum;
        bit_d  = bit_q;
        if (ready_q) begin
            if ({1'b0, smp_q} < lo_d) begin
                bit_d = 1'b1;
            end else if ({1'b0, smp_q} > hi_d) begin
                bit_d = 1'b0;
            end
        end
        old_d = (fill_q == FULL) ? ram_rd : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            smp_q   <= '0;
            avg_q   <= '0;
            total_q <= '0;
            wptr_q  <= '0;
            fill_q  <= '0;
            ready_q <= 1'b0;
            bit_q   <= 1'b0;
            edge_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            edge_q <= 1'b0;
            if (ev && (state_q != IDLE)) begin
                ovr_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (ev) begin
                        smp_q   <= din;
                        state_q <= READ;
                    end
                end
                READ: begin
                    state_q <= ACC;
                end
                ACC: begin
                    total_q <= total_q - TW'(old_d) + TW'(smp_q);
                    wptr_q  <= wptr_q + DEPTH_LOG2'(1);
                    if (fill_q != FULL) begin
                        fill_q <= fill_q + (DEPTH_LOG2+1)'(1);
                    end
                    if (fill_q == FULL_M1) begin
                        ready_q <= 1'b1;
                    end
                    state_q <= CMP;
                end
                CMP: begin
                    avg_q   <= avg_d;
                    bit_q   <= bit_d;
                    edge_q  <= bit_d ^ bit_q;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bit_out  = bit_q;
    assign bit_edge = edge_q;
    assign avg      = avg_q;
    assign ready    = ready_q;
    assign overrun  = ovr_q;

`ifdef ADC_SLICER_PERIOD_EN
    logic [PER_W-1:0] pcnt_q;
    logic [PER_W-1:0] period_q;
    logic             pval_q;

    // Counting at CMP (once per accepted sample) lets the edge sample itself restart the count at 1.
    always_ff @(posedge clk) begin
        if (reset) begin
            pcnt_q   <= '0;
            period_q <= '0;
            pval_q   <= 1'b0;
        end else begin
            pval_q <= 1'b0;
            if (state_q == CMP) begin
                if (bit_d != bit_q) begin
                    period_q <= pcnt_q;
                    pval_q   <= 1'b1;
                    pcnt_q   <= PER_W'(1);
                end else if (pcnt_q != '1) begin
                    pcnt_q <= pcnt_q + PER_W'(1);
                end
            end
        end
    end

    assign period       = period_q;
    assign period_valid = pval_q;
`else
    assign period       = '0;
    assign period_valid = 1'b0;
`endif

endmodule
